round_sequencer: RTL and testbench
==================================

# round_sequencer

Round-level scheduler for the two-player cat/dog/chicken game. It debounces nothing but synchronises the "continue" key, latches player 1 and player 2 choices on successive presses, judges the round, and updates both scores. It then requests a sprite draw of the matching scenario from the drawing datapath/controller pair through a req/done handshake, and holds the result on screen for a fixed time. It sits between the board inputs (KEY/SW) and the drawing controller, replacing ad-hoc scenario decode in the top level.

## Interface
- `WIN_SCORE`, 5: score that ends the game (used only with `ROUND_SEQ_WIN_LIMIT_EN`); 1..9.
- `HOLD_CYCLES`, 50000000: cycles the result stays displayed after draw completes; ≥1.
- `clk`  in  1  system clock (CLOCK_50).
- `resetn`  in  1  reset; one clock; reset is synchronous and active-low.
- `user_cont_n`  in  1  raw continue key, active-low, asynchronous to clk.
- `choice`  in  3  one-hot choice from switches: 001 cat, 010 dog, 100 chicken.
- `draw_done`  in  1  one-cycle pulse from drawing controller: scene finished.
- `draw_req`  out  1  request to draw `scene`; held until `draw_done`.
- `scene`  out  4  scenario index = 3·p1 + p2 (cat 0, dog 1, chicken 2); 0..8.
- `winner`  out  2  00 tie, 01 player 1, 10 player 2; valid from JUDGE onward.
- `p1_score`, `p2_score`  out  4 each  scores, binary 0..9, drive HEX decoders.
- `busy`  out  1  high in every state except WAIT1 and WAIT2.
- `game_over`  out  1  high in OVER state (constant 0 without macro).

## Operation
- Key path: two-flop synchroniser on `user_cont_n`, then edge register; `press` = previous synced value 1 and current synced value 0 (falling edge). One press = one pulse regardless of hold length.
- Choice decode: non-one-hot `choice` (000, 011, 111, …) decodes as cat.
- States and transitions:
  - WAIT1: on `press`, latch decoded `choice` into p1 reg → WAIT2.
  - WAIT2: on `press`, latch into p2 reg → JUDGE.
  - JUDGE (1 cycle): dog beats cat, cat beats chicken, chicken beats dog; equal = tie. Register `winner` and `scene`. Increment winner's score, saturating at 9 → DRAW.
  - DRAW: `draw_req`=1; on `draw_done` → HOLD, hold counter cleared.
  - HOLD: count to `HOLD_CYCLES`-1 → WAIT1 (or OVER, see Configuration).
  - OVER: absorbing until reset.
- `press` outside WAIT1/WAIT2 is discarded (not queued).
- `draw_done` outside DRAW is ignored.
- `scene` and `winner` are stable from JUDGE exit until the next JUDGE.
- Reset (any state, including mid-DRAW/HOLD): state WAIT1, both scores 0, `draw_req` 0, `scene` 0, `winner` 00, `busy` 0, `game_over` 0, choice regs cat, synchroniser flops 1 (key released), hold counter 0.

## Timing
- Key falling at edge n (sampled low first at n): `press` high during cycle after edge n+2; FSM state changes at edge n+3.
- JUDGE lasts exactly 1 cycle. `draw_req` rises on the edge leaving JUDGE. Scores update on the same edge.
- `draw_req` falls on the edge that samples `draw_done`=1. `draw_done` coincident with DRAW entry is not seen, since DRAW is entered on that edge.
- HOLD lasts exactly `HOLD_CYCLES` cycles. Round cycle latency from second press to WAIT1 = 1 + 1 + draw time + `HOLD_CYCLES`.
- Hold counter width: ceil(log2(`HOLD_CYCLES`)), min 1.

## Configuration
- `ROUND_SEQ_WIN_LIMIT_EN` defined: on HOLD exit, if either score ≥ `WIN_SCORE`, go to OVER. `game_over`=1 and `busy`=1 until reset, and presses are ignored.
- Undefined: HOLD always returns to WAIT1, scores saturate at 9, `game_over` tied 0, no OVER state logic.

## Test plan
- Reset then idle: all outputs 0, state WAIT1; hold `user_cont_n` low 100 cycles → exactly one p1 latch, no second.
- P1 dog (010), P2 cat (001): `scene`=3, `winner`=01, `p1_score`=1, `draw_req` high until `draw_done` pulse, then `HOLD_CYCLES`(=8 in bench) cycles to WAIT1.
- P1 chicken, P2 chicken → `scene`=8, `winner`=00, scores unchanged; P1 110 (invalid), P2 chicken → treated cat vs chicken, `scene`=2, `winner`=01.
- Presses during DRAW/HOLD and stray `draw_done` in WAIT1 → no state or score change.
- Assert `resetn`=0 mid-DRAW with `p2_score`=3 → next cycle `draw_req`=0, scores 0, WAIT1.
- With macro, `WIN_SCORE`=2: two P2 wins → OVER after HOLD, `game_over`=1, presses ignored. Without macro: ten P1 wins → `p1_score` stays 9.

Source files
------------

// File: rtl/round_sequencer.sv
// round_sequencer: round-level FSM for the cat/dog/chicken game (key sync, judge, scores, draw handshake, hold).
// Optional ROUND_SEQ_WIN_LIMIT_EN: stop in OVER once a score reaches WIN_SCORE.
module round_sequencer #(
    parameter int WIN_SCORE   = 5,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic       i_user_cont_n,
    input  logic [2:0] i_choice,
    input  logic       i_draw_done,
    output logic       o_draw_req,
    output logic [3:0] o_scene,
    output logic [1:0] o_winner,
    output logic [3:0] o_p1_score,
    output logic [3:0] o_p2_score,
    output logic       o_busy,
    output logic       o_game_over
);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    if (WIN_SCORE < 1 || WIN_SCORE > 9 || HOLD_CYCLES < 1) begin : g_bad_param
        $error("round_sequencer: WIN_SCORE must be 1..9 and HOLD_CYCLES >= 1");
    end

    typedef enum logic [2:0] {S_WAIT1, S_WAIT2, S_JUDGE, S_DRAW, S_HOLD, S_OVER} state_t;

    state_t           r_state, w_next;
    logic             r_s1, r_s2, r_s2_d, r_press;
    logic [1:0]       r_p1, r_p2, w_pick, w_p2_succ, w_winner;
    logic [1:0]       r_winner;
    logic [3:0]       r_scene, w_scene;
    logic [3:0]       r_p1_score, r_p2_score;
    logic [CNT_W-1:0] r_cnt;
    logic             w_hold_end;

    assign w_pick     = (i_choice == 3'b010) ? 2'd1 : (i_choice == 3'b100) ? 2'd2 : 2'd0;
    // p1 wins when its pick is the one that follows p2's in the cat->dog->chicken cycle
    assign w_p2_succ  = (r_p2 == 2'd2) ? 2'd0 : r_p2 + 2'd1;
    assign w_winner   = (r_p1 == r_p2) ? 2'b00 : (r_p1 == w_p2_succ) ? 2'b01 : 2'b10;
    assign w_scene    = 4'(r_p1) * 4'd3 + 4'(r_p2);
    assign w_hold_end = (r_cnt == HOLD_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_resetn) r_state <= S_WAIT1;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT1: w_next = r_press ? S_WAIT2 : S_WAIT1;
            S_WAIT2: w_next = r_press ? S_JUDGE : S_WAIT2;
            S_JUDGE: w_next = S_DRAW;
            S_DRAW:  w_next = i_draw_done ? S_HOLD : S_DRAW;
`ifdef ROUND_SEQ_WIN_LIMIT_EN
            S_HOLD:  w_next = !w_hold_end ? S_HOLD :
                              (r_p1_score >= 4'(WIN_SCORE) || r_p2_score >= 4'(WIN_SCORE)) ? S_OVER : S_WAIT1;
`else
            S_HOLD:  w_next = w_hold_end ? S_WAIT1 : S_HOLD;
`endif
            default: w_next = r_state;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_s1       <= 1'b1;
            r_s2       <= 1'b1;
            r_s2_d     <= 1'b1;
            r_press    <= 1'b0;
            r_p1       <= 2'd0;
            r_p2       <= 2'd0;
            r_winner   <= 2'b00;
            r_scene    <= 4'd0;
            r_p1_score <= 4'd0;
            r_p2_score <= 4'd0;
            r_cnt      <= '0;
        end else begin
            r_s1    <= i_user_cont_n;
            r_s2    <= r_s1;
            r_s2_d  <= r_s2;
            r_press <= r_s2_d & ~r_s2;
            if (r_state == S_WAIT1 && r_press) r_p1 <= w_pick;
            if (r_state == S_WAIT2 && r_press) r_p2 <= w_pick;
            if (r_state == S_JUDGE) begin
                r_winner <= w_winner;
                r_scene  <= w_scene;
                if (w_winner == 2'b01 && r_p1_score != 4'd9) r_p1_score <= r_p1_score + 4'd1;
                if (w_winner == 2'b10 && r_p2_score != 4'd9) r_p2_score <= r_p2_score + 4'd1;
            end
            r_cnt <= (r_state == S_HOLD) ? r_cnt + 1'b1 : '0;
        end
    end

    assign o_draw_req = (r_state == S_DRAW);
    assign o_busy     = (r_state != S_WAIT1) && (r_state != S_WAIT2);
    assign o_scene    = r_scene;
    assign o_winner   = r_winner;
    assign o_p1_score = r_p1_score;
    assign o_p2_score = r_p2_score;
`ifdef ROUND_SEQ_WIN_LIMIT_EN
    assign o_game_over = (r_state == S_OVER);
`else
    assign o_game_over = 1'b0;
`endif
endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: random rounds against a rule-level model of the game (scores, scene, winner, timing).
module tb_round_sequencer;
    localparam int HOLD = 8;
    localparam int WIN  = 2;

    logic       i_clk = 1'b0;
    logic       i_resetn = 1'b0;
    logic       i_user_cont_n = 1'b1;
    logic [2:0] i_choice = 3'b000;
    logic       i_draw_done = 1'b0;
    logic       o_draw_req, o_busy, o_game_over;
    logic [3:0] o_scene, o_p1_score, o_p2_score;
    logic [1:0] o_winner;

    int n_vec = 0;
    int n_err = 0;
    int m_s1 = 0;
    int m_s2 = 0;
    bit m_over = 1'b0;

    round_sequencer #(.WIN_SCORE(WIN), .HOLD_CYCLES(HOLD)) dut (
        .i_clk(i_clk), .i_resetn(i_resetn), .i_user_cont_n(i_user_cont_n),
        .i_choice(i_choice), .i_draw_done(i_draw_done), .o_draw_req(o_draw_req),
        .o_scene(o_scene), .o_winner(o_winner), .o_p1_score(o_p1_score),
        .o_p2_score(o_p2_score), .o_busy(o_busy), .o_game_over(o_game_over)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int dec(input logic [2:0] c);
        if (c == 3'b010) return 1;
        if (c == 3'b100) return 2;
        return 0;
    endfunction

    function automatic bit beats(input int a, input int b);
        return (a == 1 && b == 0) || (a == 0 && b == 2) || (a == 2 && b == 1);
    endfunction

    function automatic int judge(input int a, input int b);
        if (a == b) return 0;
        return beats(a, b) ? 1 : 2;
    endfunction

    task automatic do_reset();
        i_resetn = 1'b0;
        i_user_cont_n = 1'b1;
        i_draw_done = 1'b0;
        repeat (2) @(negedge i_clk);
        i_resetn = 1'b1;
        m_s1 = 0;
        m_s2 = 0;
        m_over = 1'b0;
        @(negedge i_clk);
        check("rst_draw_req", o_draw_req, 0);
        check("rst_scene", o_scene, 0);
        check("rst_winner", o_winner, 0);
        check("rst_p1_score", o_p1_score, 0);
        check("rst_p2_score", o_p2_score, 0);
        check("rst_busy", o_busy, 0);
        check("rst_game_over", o_game_over, 0);
    endtask

    task automatic play_round(input logic [2:0] c1, input logic [2:0] c2, input int lat,
                              input bit inject, input int h1, input bit abort);
        int p1, p2, w;
        if (m_over) do_reset();
        p1 = dec(c1);
        p2 = dec(c2);
        w = judge(p1, p2);
        if (w == 1 && m_s1 < 9) m_s1++;
        if (w == 2 && m_s2 < 9) m_s2++;
        if (inject) begin
            i_draw_done = 1'b1;
            @(negedge i_clk);
            i_draw_done = 1'b0;
            @(negedge i_clk);
            check("stray_done_idle", o_busy, 0);
        end
        i_choice = c1;
        i_user_cont_n = 1'b0;
        repeat (h1) @(negedge i_clk);
        i_user_cont_n = 1'b1;
        repeat (4) @(negedge i_clk);
        check("wait2_busy", o_busy, 0);
        check("wait2_req", o_draw_req, 0);
        i_choice = c2;
        i_user_cont_n = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge i_clk);
            if (i == 4) check("judge_req", o_draw_req, 0);
        end
        check("draw_req_rise", o_draw_req, 1);
        i_user_cont_n = 1'b1;
        i_choice = 3'($urandom);
        check("scene", o_scene, p1 * 3 + p2);
        check("winner", o_winner, w);
        check("p1_score", o_p1_score, m_s1);
        check("p2_score", o_p2_score, m_s2);
        check("draw_busy", o_busy, 1);
        check("draw_game_over", o_game_over, 0);
        if (abort) begin
            i_resetn = 1'b0;
            @(negedge i_clk);
            i_resetn = 1'b1;
            m_s1 = 0;
            m_s2 = 0;
            m_over = 1'b0;
            check("abort_draw_req", o_draw_req, 0);
            check("abort_p1_score", o_p1_score, 0);
            check("abort_p2_score", o_p2_score, 0);
            check("abort_busy", o_busy, 0);
            check("abort_scene", o_scene, 0);
            return;
        end
        for (int i = 0; i < lat; i++) begin
            if (inject && i == 0) i_user_cont_n = 1'b0;
            if (inject && i == 2) i_user_cont_n = 1'b1;
            @(negedge i_clk);
        end
        check("draw_req_held", o_draw_req, 1);
        check("scene_stable", o_scene, p1 * 3 + p2);
        i_draw_done = 1'b1;
        @(negedge i_clk);
        i_draw_done = 1'b0;
        check("draw_req_fall", o_draw_req, 0);
        check("hold_entry_busy", o_busy, 1);
`ifdef ROUND_SEQ_WIN_LIMIT_EN
        m_over = (m_s1 >= WIN) || (m_s2 >= WIN);
`endif
        for (int c = 1; c <= HOLD; c++) begin
            @(negedge i_clk);
            if (inject && c == 1) i_user_cont_n = 1'b0;
            if (inject && c == 3) i_user_cont_n = 1'b1;
            if (c == HOLD - 1) check("hold_busy", o_busy, 1);
        end
        check("hold_exit_busy", o_busy, int'(m_over));
        check("hold_exit_game_over", o_game_over, int'(m_over));
        check("end_p1_score", o_p1_score, m_s1);
        check("end_p2_score", o_p2_score, m_s2);
        check("end_winner", o_winner, w);
    endtask

    initial begin
        do_reset();
        play_round(3'b010, 3'b001, 3, 1'b0, 100, 1'b0);
        play_round(3'b100, 3'b100, 5, 1'b0, 2, 1'b0);
        play_round(3'b110, 3'b100, 2, 1'b0, 1, 1'b0);
        play_round(3'b001, 3'b010, 9, 1'b1, 3, 1'b0);
        do_reset();
        repeat (3) play_round(3'b001, 3'b010, 4, 1'b0, 2, 1'b0);
        play_round(3'b010, 3'b001, 4, 1'b0, 2, 1'b1);
        do_reset();
`ifdef ROUND_SEQ_WIN_LIMIT_EN
        repeat (2) play_round(3'b001, 3'b010, 3, 1'b0, 2, 1'b0);
        i_user_cont_n = 1'b0;
        repeat (5) @(negedge i_clk);
        i_user_cont_n = 1'b1;
        repeat (4) @(negedge i_clk);
        check("over_busy", o_busy, 1);
        check("over_game_over", o_game_over, 1);
        check("over_draw_req", o_draw_req, 0);
        check("over_p2_score", o_p2_score, m_s2);
`else
        repeat (10) play_round(3'b010, 3'b001, 2, 1'b0, 1, 1'b0);
        check("p1_saturate", o_p1_score, 9);
`endif
        repeat (40) begin
            int lat;
            bit inj;
            lat = $urandom_range(1, 12);
            inj = ($urandom_range(0, 3) == 0);
            if (inj && lat < 8) lat = 8;
            play_round(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), lat, inj,
                       $urandom_range(1, 6), 1'b0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
